bpu_bht: RTL and testbench
==========================

// Module: bpu_bht
// PURPOSE
//  Branch history table for bxx conditional branches in the fetch stage. Each
//  lookup reads a 2-bit saturating counter indexed by the fetch PC. When the
//  counter predicts taken, the block asserts bxx_pre_hit and returns the target
//  PC + offset. The predict/fix logic in WB reports the resolved outcome of each
//  branch, and the indexed counter is trained toward that outcome. This block is
//  the consumer of that unit's bxxjump_success/fail/fix_pc strobes.
// PARAMETERS
//  BHT_IDX_W   6                 index width; table holds 2**BHT_IDX_W counters
//  CNT_RST     2'b01             per-entry reset value (weakly not-taken)
//  ADDR_W      `ZCRV_ADDR_SIZE   PC width; taken from defines.v
// PORTS
//  clk                      in   1       core clock, rising edge
//  rst_n                    in   1       asynchronous reset, active-low
//  pc_from_ifu              in   ADDR_W  fetch PC being looked up
//  op_bxx_from_ifu          in   1       pre-decode: fetched instruction is bxx
//  bxx_imm_from_ifu         in   13      B-type offset (bit0 = 0), signed
//  bxx_pre_hit_to_ifu       out  1       predicted taken
//  pre_jump_dest_to_ifu     out  ADDR_W  predicted target PC
//  bxxjump_success_from_fix in   1       resolved bxx was taken
//  bxxjump_fail_from_fix    in   1       resolved bxx was not taken
//  fix_pc_from_fix          in   ADDR_W  PC of the resolved bxx
// BEHAVIOUR
//  - Storage: cnt[0 .. 2**BHT_IDX_W-1], 2 bits each. rst_n low sets every entry
//    to CNT_RST immediately (asynchronous). Any in-flight update is dropped.
//  - Lookup index  ridx = pc_from_ifu[BHT_IDX_W+1:2].
//    Update index  widx = fix_pc_from_fix[BHT_IDX_W+1:2].
//    Bits [1:0] of either PC are ignored.
//  - Lookup is combinational with zero latency:
//      bxx_pre_hit_to_ifu   = op_bxx_from_ifu & cnt[ridx][1]
//      pre_jump_dest_to_ifu = pc + sext(bxx_imm), computed modulo 2**ADDR_W
//    When bxx_pre_hit is 0, pre_jump_dest is driven as 0.
//  - Output values during reset (rst_n low, op_bxx=1): pre_hit reads the reset
//    counters, so it is 0 when CNT_RST[1]=0. No output has its own register.
//  - Update happens on the rising clk edge that samples a strobe:
//      success : cnt[widx] <= (cnt == 2'b11) ? 2'b11 : cnt + 1
//      fail    : cnt[widx] <= (cnt == 2'b00) ? 2'b00 : cnt - 1
//      both    : illegal from the fix unit; the entry is left unchanged
//      neither : no write
//  - Read/write same cycle, ridx == widx: the lookup returns the pre-update
//    value (no bypass). The new value is visible to a lookup on the next cycle.
//  - Only one entry is written per cycle; all other entries hold their values.
//  - Aliasing: PCs sharing index bits share one counter. No tag is kept.
//  - FSM per entry: SN(00) <-> WN(01) <-> WT(10) <-> ST(11).
//    Success moves right; fail moves left; the end states saturate.
// CONFIGURATION
//  ZCRV_BPU_GSHARE_EN defined:
//    - Adds ghr, a BHT_IDX_W-bit global history register; reset value 0.
//    - ridx = pc[BHT_IDX_W+1:2] ^ ghr.
//    - widx = fix_pc[BHT_IDX_W+1:2] ^ ghr_at_update, where ghr_at_update is the
//      ghr value before the shift below.
//    - On each legal strobe: ghr <= {ghr[BHT_IDX_W-2:0], success}.
//    - Both-strobes cycle: ghr is unchanged.
//  ZCRV_BPU_GSHARE_EN undefined:
//    - No ghr register. Indexing uses the PC bits only, as in BEHAVIOUR.
// TESTING
//  1. Reset, then lookup pc=0x100, op_bxx=1, imm=0x10
//     -> pre_hit=0, dest=0.
//  2. Two success strobes, fix_pc=0x100; then lookup 0x100, imm=0x10
//     -> pre_hit=1, dest=0x110 (counter 01->10->11).
//  3. From ST, three fail strobes on 0x100, then a fourth fail
//     -> counter 11->10->01->00, stays 00; pre_hit=0.
//  4. Same cycle: lookup 0x100 and success on 0x100, counter at 01
//     -> pre_hit=0 that cycle, pre_hit=1 next cycle.
//  5. Aliasing and range: success x2 on 0x100, then lookup 0x200 (BHT_IDX_W=6)
//     -> pre_hit=1. Also pc=0x4, imm=-8 -> dest wraps to 0xFFFF_FFFC.
//  6. Both strobes asserted, then rst_n pulsed low mid-training
//     -> entry unchanged on the both-strobes cycle; after reset all counters
//        read 01. With GSHARE_EN, ghr also reads 0 after reset.

Source files
------------

// File: rtl/bpu_bht.sv
// Branch history table: 2-bit saturating counters indexed by fetch PC, trained by fix-unit strobes.
// Optional gshare indexing (global history XOR PC bits) when ZCRV_BPU_GSHARE_EN is defined.
`ifndef ZCRV_ADDR_SIZE
  `define ZCRV_ADDR_SIZE 32
`endif

module bpu_bht #(
  parameter int         BHT_IDX_W = 6,
  parameter logic [1:0] CNT_RST   = 2'b01,
  parameter int         ADDR_W    = `ZCRV_ADDR_SIZE
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   pc_from_ifu,
  input  logic                op_bxx_from_ifu,
  input  logic signed [12:0]  bxx_imm_from_ifu,
  output logic                bxx_pre_hit_to_ifu,
  output logic [ADDR_W-1:0]   pre_jump_dest_to_ifu,
  input  logic                bxxjump_success_from_fix,
  input  logic                bxxjump_fail_from_fix,
  input  logic [ADDR_W-1:0]   fix_pc_from_fix
);

  localparam int DEPTH = 2 ** BHT_IDX_W;

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'b11) ? 2'b11 : c + 2'b01;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == 2'b00) ? 2'b00 : c - 2'b01;
  endfunction

  logic [1:0]               r_cnt [DEPTH];
  logic [BHT_IDX_W-1:0]     w_ridx;
  logic [BHT_IDX_W-1:0]     w_widx;
  logic                     w_upd;
  logic [1:0]               w_cnt_nxt;
  logic signed [ADDR_W-1:0] w_imm_sext;
  logic [ADDR_W-1:0]        w_target;
  logic                     w_unused;

  // Both strobes together is illegal from the fix unit and is treated as no update.
  assign w_upd = bxxjump_success_from_fix ^ bxxjump_fail_from_fix;

`ifdef ZCRV_BPU_GSHARE_EN
  logic [BHT_IDX_W-1:0] r_ghr;

  assign w_ridx = pc_from_ifu[BHT_IDX_W+1:2] ^ r_ghr;
  assign w_widx = fix_pc_from_fix[BHT_IDX_W+1:2] ^ r_ghr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ghr <= '0;
    end else if (w_upd) begin
      r_ghr <= {r_ghr[BHT_IDX_W-2:0], bxxjump_success_from_fix};
    end
  end
`else
  assign w_ridx = pc_from_ifu[BHT_IDX_W+1:2];
  assign w_widx = fix_pc_from_fix[BHT_IDX_W+1:2];
`endif

  assign w_cnt_nxt = bxxjump_success_from_fix ? sat_inc(r_cnt[w_widx])
                                              : sat_dec(r_cnt[w_widx]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_cnt[i] <= CNT_RST;
      end
    end else if (w_upd) begin
      r_cnt[w_widx] <= w_cnt_nxt;
    end
  end

  // Lookup reads the stored counter directly, so a same-cycle update is not bypassed.
  assign w_imm_sext           = ADDR_W'(bxx_imm_from_ifu);
  assign w_target             = pc_from_ifu + $unsigned(w_imm_sext);
  assign bxx_pre_hit_to_ifu   = op_bxx_from_ifu & r_cnt[w_ridx][1];
  assign pre_jump_dest_to_ifu = bxx_pre_hit_to_ifu ? w_target : '0;

  assign w_unused = ^{fix_pc_from_fix[ADDR_W-1:BHT_IDX_W+2], fix_pc_from_fix[1:0]};

endmodule

// File: tb/tb_bpu_bht.sv
// Randomized and directed bench for bpu_bht against a table-of-integers reference model.
module tb_bpu_bht;
  localparam int IDXW   = 6;
  localparam int N      = 2 ** IDXW;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [ADDR_W-1:0] pc_from_ifu = '0;
  logic              op_bxx_from_ifu = 1'b0;
  logic signed [12:0] bxx_imm_from_ifu = '0;
  logic              bxx_pre_hit_to_ifu;
  logic [ADDR_W-1:0] pre_jump_dest_to_ifu;
  logic              bxxjump_success_from_fix = 1'b0;
  logic              bxxjump_fail_from_fix = 1'b0;
  logic [ADDR_W-1:0] fix_pc_from_fix = '0;

  bpu_bht #(.BHT_IDX_W(IDXW), .CNT_RST(2'b01), .ADDR_W(ADDR_W)) dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .pc_from_ifu              (pc_from_ifu),
    .op_bxx_from_ifu          (op_bxx_from_ifu),
    .bxx_imm_from_ifu         (bxx_imm_from_ifu),
    .bxx_pre_hit_to_ifu       (bxx_pre_hit_to_ifu),
    .pre_jump_dest_to_ifu     (pre_jump_dest_to_ifu),
    .bxxjump_success_from_fix (bxxjump_success_from_fix),
    .bxxjump_fail_from_fix    (bxxjump_fail_from_fix),
    .fix_pc_from_fix          (fix_pc_from_fix)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int mcnt [N];
  int mghr = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int midx(input longint pc);
    return int'((pc / 4) % N) ^ mghr;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < N; i++) mcnt[i] = 1;
    mghr = 0;
  endfunction

  // One cycle: drive lookup and strobes, check lookup against pre-update model, then train model.
  task automatic step(input logic [31:0] pc, input bit op, input int imm,
                      input bit s, input bit f, input logic [31:0] fpc,
                      input int lit_hit, input longint lit_dest);
    longint exp_dest;
    bit     exp_hit;
    int     i;
    @(negedge clk);
    pc_from_ifu              = pc;
    op_bxx_from_ifu          = op;
    bxx_imm_from_ifu         = 13'(imm);
    bxxjump_success_from_fix = s;
    bxxjump_fail_from_fix    = f;
    fix_pc_from_fix          = fpc;
    #1;
    exp_hit  = op && (mcnt[midx(longint'(pc))] >= 2);
    exp_dest = exp_hit ? ((longint'(pc) + longint'(imm)) & 64'hFFFF_FFFF) : 0;
    chk("hit", longint'(bxx_pre_hit_to_ifu), longint'(exp_hit));
    chk("dest", longint'(pre_jump_dest_to_ifu), exp_dest);
`ifndef ZCRV_BPU_GSHARE_EN
    if (lit_hit >= 0) chk("lit_hit", longint'(bxx_pre_hit_to_ifu), longint'(lit_hit));
    if (lit_dest >= 0) chk("lit_dest", longint'(pre_jump_dest_to_ifu), lit_dest);
`endif
    @(posedge clk);
    #1;
    if (s != f) begin
      i = midx(longint'(fpc));
      mcnt[i] = s ? ((mcnt[i] == 3) ? 3 : mcnt[i] + 1) : ((mcnt[i] == 0) ? 0 : mcnt[i] - 1);
`ifdef ZCRV_BPU_GSHARE_EN
      mghr = ((mghr * 2) + int'(s)) % N;
`endif
    end
  endtask

  // Async reset pulse spanning one rising edge; optionally with a success strobe that must be dropped.
  task automatic do_reset(input bit strobe_during);
    @(negedge clk);
    rst_n                    = 1'b0;
    bxxjump_success_from_fix = strobe_during;
    bxxjump_fail_from_fix    = 1'b0;
    fix_pc_from_fix          = 32'h100;
    op_bxx_from_ifu          = 1'b1;
    pc_from_ifu              = 32'h100;
    bxx_imm_from_ifu         = 13'h10;
    model_reset();
    #1;
    chk("rst_hit", longint'(bxx_pre_hit_to_ifu), 0);
    chk("rst_dest", longint'(pre_jump_dest_to_ifu), 0);
    @(negedge clk);
    chk("rst_hold_hit", longint'(bxx_pre_hit_to_ifu), 0);
    rst_n                    = 1'b1;
    bxxjump_success_from_fix = 1'b0;
  endtask

  initial begin
    logic [31:0] pool [4];
    logic [31:0] pc, fpc;
    int          r, imm;
    bit          s, f;
    pool[0] = 32'h100; pool[1] = 32'h200; pool[2] = 32'h104; pool[3] = 32'h4;
    model_reset();

    // 1: reset lookup
    do_reset(1'b0);
    step(32'h100, 1, 'h10, 0, 0, 0, 0, 0);
    // 2: two successes then taken prediction
    step(32'h100, 0, 'h10, 1, 0, 32'h100, -1, -1);
    step(32'h100, 0, 'h10, 1, 0, 32'h100, -1, -1);
    step(32'h100, 1, 'h10, 0, 0, 0, 1, 'h110);
    // 3: four fails saturate at 00; one success gives 01 (not taken)
    for (int k = 0; k < 4; k++) step(32'h100, 0, 0, 0, 1, 32'h100, -1, -1);
    step(32'h100, 1, 'h10, 0, 0, 0, 0, 0);
    step(32'h100, 0, 0, 1, 0, 32'h100, -1, -1);
    // 4: same-cycle read returns pre-update value
    step(32'h100, 1, 'h10, 1, 0, 32'h100, 0, 0);
    step(32'h100, 1, 'h10, 0, 0, 0, 1, 'h110);
    // 5: aliasing and wrap
    step(32'h100, 0, 0, 1, 0, 32'h100, -1, -1);
    step(32'h200, 1, 'h10, 0, 0, 0, 1, 'h210);
    step(32'h4, 0, 0, 1, 0, 32'h4, -1, -1);
    step(32'h4, 0, 0, 1, 0, 32'h4, -1, -1);
    step(32'h4, 1, -8, 0, 0, 0, 1, 'hFFFF_FFFC);
    // 6: both strobes leave entry at 11, then two fails reach 01
    step(32'h100, 0, 0, 1, 1, 32'h100, -1, -1);
    step(32'h100, 0, 0, 0, 1, 32'h100, -1, -1);
    step(32'h100, 1, 'h10, 0, 0, 0, 1, 'h110);
    step(32'h100, 0, 0, 0, 1, 32'h100, -1, -1);
    step(32'h100, 1, 'h10, 0, 0, 0, 0, 0);
    step(32'h100, 0, 0, 1, 0, 32'h100, -1, -1);
    step(32'h100, 0, 0, 1, 0, 32'h100, -1, -1);
    do_reset(1'b1);
    step(32'h100, 1, 'h10, 0, 0, 0, 0, 0);
    step(32'h4, 1, -8, 0, 0, 0, 0, 0);
    step(32'h100, 0, 0, 1, 0, 32'h100, -1, -1);
    step(32'h100, 1, 'h10, 0, 0, 0, 1, 'h110);

    // Randomized traffic over a small aliasing-prone PC pool plus random PCs
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) do_reset($urandom_range(0, 1) == 1);
      pc  = ($urandom_range(0, 3) == 0) ? ($urandom() & 32'hFFFF_FFFC) : pool[$urandom_range(0, 3)];
      fpc = ($urandom_range(0, 3) == 0) ? $urandom() : pool[$urandom_range(0, 3)];
      imm = int'($urandom_range(0, 8191)) - 4096;
      imm = imm & ~1;
      r   = $urandom_range(0, 9);
      s   = (r <= 3) || (r == 7);
      f   = (r >= 4 && r <= 7);
      step(pc, $urandom_range(0, 3) != 0, imm, s, f, fpc, -1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
